data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/data_mem_ctrl_if.sv | 21 ++
 rtl/dmem_array.sv | 28 ++
 rtl/data_mem_ctrl.sv | 127 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory controller: FSM state encoding, default base
// address and the address range check.
package dmem_pkg;

  typedef logic [1:0] dmem_state_t;

  localparam dmem_state_t IDLE = 2'b00;
  localparam dmem_state_t WAIT = 2'b01;
  localparam dmem_state_t DONE = 2'b10;

  localparam logic [31:0] DMEM_BASE_ADDR_DEFAULT = 32'h1001_0000;

  // 33-bit offset so that base + span never wraps around the 32-bit address space.
  function automatic logic dmem_in_range(input logic [31:0] addr, input logic [31:0] base,
                                         input logic [32:0] span);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return (addr >= base) && (off < span);
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Processor-side memory bus: request from the MEM stage, response back to the core.
interface data_mem_ctrl_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
  logic [31:0] dReadData;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output MemRead, MemWrite, dAddress, dWriteData,
    input  dReadData, ready, busy, err
  );

  modport slave (
    input  MemRead, MemWrite, dAddress, dWriteData,
    output dReadData, ready, busy, err
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with write enable and registered read; never reset.
module dmem_array #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Wait-state data memory controller with sticky fault flag.
// Define DMEM_MISALIGN_TRAP_EN to fault on addresses with dAddress[1:0] != 0.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR_DEFAULT,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic            clk,
  input logic            rst,
  data_mem_ctrl_if.slave bus_io
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q;
  logic          ready_q, busy_q, err_q;
  logic          write_q, fault_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;

  logic          accept, misalign, req_fault;
  logic [31:0]   offset;
  logic [AW-1:0] req_idx;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;
  logic          unused_offset;

  assign accept  = (state_q == IDLE) && (bus_io.MemRead || bus_io.MemWrite);
  assign offset  = bus_io.dAddress - BASE_ADDR;
  assign req_idx = offset[AW+1:2];
  assign unused_offset = ^{offset[31:AW+2], offset[1:0]};

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = |bus_io.dAddress[1:0];
`else
  assign misalign = 1'b0;
`endif

  assign req_fault = misalign ||
                     !dmem_in_range(bus_io.dAddress, BASE_ADDR, 33'(DEPTH_WORDS) << 2);

  // Reads are issued at the accepting edge so the RAM output is ready by DONE; the write
  // itself happens at the DONE edge and is gated by reset to abort cleanly.
  assign ram_re   = accept && !bus_io.MemWrite;
  assign ram_we   = rst && (state_q == DONE) && write_q && !fault_q;
  assign ram_addr = (state_q == IDLE) ? req_idx : idx_q;

  dmem_array #(
    .Depth (DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
          cnt_d   = WaitInit;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_q == DONE);
      if (accept) begin
        busy_q <= 1'b1;
      end
      if (state_q == DONE) begin
        busy_q <= 1'b0;
        err_q  <= err_q | fault_q;
        if (!write_q) begin
          rdata_q <= fault_q ? 32'h0 : ram_rdata;
        end
      end
    end
  end

  // Request latches carry no reset: they are only consumed after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= bus_io.MemWrite;
      fault_q <= req_fault;
      idx_q   <= req_idx;
      wdata_q <= bus_io.dWriteData;
    end
  end

  assign bus_io.dReadData = rdata_q;
  assign bus_io.ready     = ready_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.err       = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench: two controllers (0 and 3 wait states) against a transaction-level model.
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  localparam logic [31:0] Base  = 32'h1001_0000;
  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  logic rst0, rst3;
  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [2][Depth];
  logic        err_m [2];
  logic [31:0] rd_m  [2];

  always #5 clk = ~clk;

  data_mem_ctrl_if bus0 ();
  data_mem_ctrl_if bus3 ();

  data_mem_ctrl #(.BASE_ADDR(Base), .DEPTH_WORDS(Depth), .WAIT_CYCLES(0)) dut0 (
    .clk    (clk),
    .rst    (rst0),
    .bus_io (bus0)
  );

  data_mem_ctrl #(.BASE_ADDR(Base), .DEPTH_WORDS(Depth), .WAIT_CYCLES(3)) dut3 (
    .clk    (clk),
    .rst    (rst3),
    .bus_io (bus3)
  );

  function automatic logic [31:0] get_rd(input int w);
    return (w == 0) ? bus0.dReadData : bus3.dReadData;
  endfunction
  function automatic logic get_ready(input int w);
    return (w == 0) ? bus0.ready : bus3.ready;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 0) ? bus0.busy : bus3.busy;
  endfunction
  function automatic logic get_err(input int w);
    return (w == 0) ? bus0.err : bus3.err;
  endfunction

  // Reference rules: range [Base, Base + 4*Depth), optional alignment trap.
  function automatic bit faulty(input logic [31:0] a);
    longint off;
    bit f;
    off = longint'({32'h0, a}) - longint'({32'h0, Base});
    f = (off < 0) || (off >= longint'(4 * Depth));
`ifdef DMEM_MISALIGN_TRAP_EN
    if (a[1:0] != 2'b00) f = 1'b1;
`endif
    return f;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - Base) >> 2);
  endfunction

  task automatic model_apply(input int w, input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] d);
    bit f;
    f = faulty(a);
    if (wr) begin
      if (!f) mem_m[w][word_of(a)] = d;
    end else if (rd) begin
      rd_m[w] = f ? 32'h0 : mem_m[w][word_of(a)];
    end
    if (f) err_m[w] = 1'b1;
  endtask

  task automatic drive(input int w, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d);
    if (w == 0) begin
      bus0.MemRead = rd; bus0.MemWrite = wr; bus0.dAddress = a; bus0.dWriteData = d;
    end else begin
      bus3.MemRead = rd; bus3.MemWrite = wr; bus3.dAddress = a; bus3.dWriteData = d;
    end
  endtask

  // One request, held for a single accepting edge; lat counts edges to ready (-1 on timeout).
  task automatic do_access(input int w, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, output int lat, output logic [31:0] rdata,
                           output logic e);
    @(negedge clk);
    drive(w, rd, wr, a, d);
    @(posedge clk);
    #1;
    drive(w, 1'b0, 1'b0, a, d);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (get_ready(w)) begin
        lat = c;
        break;
      end
    end
    rdata = get_rd(w);
    e     = get_err(w);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 32'h0, 32'h0);
    rst0 = 1'b0;
    rst3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      checks += 4;
      if (get_rd(w) !== 32'h0) begin
        errors++; $display("FAIL reset_rdata[%0d]: got %h expected 0", w, get_rd(w));
      end
      if (get_ready(w) !== 1'b0) begin
        errors++; $display("FAIL reset_ready[%0d]: got %b expected 0", w, get_ready(w));
      end
      if (get_busy(w) !== 1'b0) begin
        errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", w, get_busy(w));
      end
      if (get_err(w) !== 1'b0) begin
        errors++; $display("FAIL reset_err[%0d]: got %b expected 0", w, get_err(w));
      end
      err_m[w] = 1'b0;
      rd_m[w]  = 32'h0;
    end
    @(negedge clk);
    rst0 = 1'b1;
    rst3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (get_busy(w) !== 1'b0 || get_ready(w) !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset[%0d]: busy %b ready %b expected 0 0", w, get_busy(w),
                 get_ready(w));
      end
    end
  endtask

  task automatic test_init();
    int lat; logic [31:0] rd; logic e; logic [31:0] d;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < int'(Depth); i++) begin
        d = $urandom;
        do_access(w, 1'b0, 1'b1, Base + 32'(4 * i), d, lat, rd, e);
        model_apply(w, 1'b0, 1'b1, Base + 32'(4 * i), d);
      end
    end
  endtask

  task automatic test_basic_w0();
    int lat; logic [31:0] rd; logic e;
    do_access(0, 1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, lat, rd, e);
    model_apply(0, 1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF);
    checks += 3;
    if (lat !== 1) begin errors++; $display("FAIL w0_write_latency: got %0d expected 1", lat); end
    if (e !== 1'b0) begin errors++; $display("FAIL w0_write_err: got %b expected 0", e); end
    if (rd !== 32'h0) begin errors++; $display("FAIL w0_write_holds_rdata: got %h expected 0", rd); end
    do_access(0, 1'b1, 1'b0, 32'h1001_0004, 32'h0, lat, rd, e);
    model_apply(0, 1'b1, 1'b0, 32'h1001_0004, 32'h0);
    checks += 3;
    if (lat !== 1) begin errors++; $display("FAIL w0_read_latency: got %0d expected 1", lat); end
    if (rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL w0_read_data: got %h expected deadbeef", rd);
    end
    if (e !== 1'b0) begin errors++; $display("FAIL w0_read_err: got %b expected 0", e); end
  endtask

  task automatic test_both_high();
    int lat; logic [31:0] rd; logic e;
    do_access(0, 1'b1, 1'b1, 32'h1001_0008, 32'h1234_5678, lat, rd, e);
    model_apply(0, 1'b1, 1'b1, 32'h1001_0008, 32'h1234_5678);
    checks += 2;
    if (lat !== 1) begin errors++; $display("FAIL both_latency: got %0d expected 1", lat); end
    if (rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL both_rdata_unchanged: got %h expected deadbeef", rd);
    end
    do_access(0, 1'b1, 1'b0, 32'h1001_0008, 32'h0, lat, rd, e);
    model_apply(0, 1'b1, 1'b0, 32'h1001_0008, 32'h0);
    checks++;
    if (rd !== 32'h1234_5678) begin
      errors++; $display("FAIL both_word_written: got %h expected 12345678", rd);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd; logic e; logic [31:0] word0;
    do_access(0, 1'b1, 1'b0, 32'h0040_0000, 32'h0, lat, rd, e);
    model_apply(0, 1'b1, 1'b0, 32'h0040_0000, 32'h0);
    checks += 3;
    if (lat !== 1) begin errors++; $display("FAIL oor_ready: got %0d expected 1", lat); end
    if (rd !== 32'h0) begin errors++; $display("FAIL oor_rdata: got %h expected 0", rd); end
    if (e !== 1'b1) begin errors++; $display("FAIL oor_err: got %b expected 1", e); end
    do_access(0, 1'b1, 1'b0, 32'h1001_0004, 32'h0, lat, rd, e);
    model_apply(0, 1'b1, 1'b0, 32'h1001_0004, 32'h0);
    checks += 2;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL oor_then_valid_data: got %h expected deadbeef", rd);
    end
    if (e !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", e); end
    // One past the top must not alias onto word 0.
    word0 = mem_m[0][0];
    do_access(0, 1'b0, 1'b1, Base + 32'(4 * Depth), ~word0, lat, rd, e);
    model_apply(0, 1'b0, 1'b1, Base + 32'(4 * Depth), ~word0);
    do_access(0, 1'b1, 1'b0, Base, 32'h0, lat, rd, e);
    model_apply(0, 1'b1, 1'b0, Base, 32'h0);
    checks++;
    if (rd !== word0) begin
      errors++; $display("FAIL oor_write_suppressed: got %h expected %h", rd, word0);
    end
    do_access(0, 1'b1, 1'b0, Base + 32'(4 * Depth - 4), 32'h0, lat, rd, e);
    model_apply(0, 1'b1, 1'b0, Base + 32'(4 * Depth - 4), 32'h0);
    checks++;
    if (rd !== mem_m[0][Depth-1]) begin
      errors++; $display("FAIL top_word_read: got %h expected %h", rd, mem_m[0][Depth-1]);
    end
  endtask

  task automatic test_wait_states();
    int busy_cnt; int ready_at; int ready_cnt; logic [31:0] a;
    a = Base + 32'd12;
    busy_cnt = 0; ready_at = -1; ready_cnt = 0;
    @(negedge clk);
    drive(1, 1'b1, 1'b0, a, 32'h0);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, a, 32'h0);
    model_apply(1, 1'b1, 1'b0, a, 32'h0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (bus3.busy) busy_cnt++;
      drive(1, c == 2, 1'b0, Base + 32'd16, 32'h0);
      @(posedge clk);
      #1;
      if (bus3.ready) begin
        ready_cnt++;
        if (ready_at < 0) ready_at = c;
      end
      if (c == 4) begin
        checks++;
        if (bus3.dReadData !== rd_m[1]) begin
          errors++; $display("FAIL w3_read_data: got %h expected %h", bus3.dReadData, rd_m[1]);
        end
      end
    end
    checks += 3;
    if (busy_cnt !== 4) begin errors++; $display("FAIL w3_busy_cycles: got %0d expected 4", busy_cnt); end
    if (ready_at !== 4) begin errors++; $display("FAIL w3_ready_cycle: got %0d expected 4", ready_at); end
    if (ready_cnt !== 1) begin
      errors++; $display("FAIL w3_second_read_ignored: ready pulses %0d expected 1", ready_cnt);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic e; logic [31:0] old; int ready_cnt;
    old = mem_m[1][5];
    @(negedge clk);
    drive(1, 1'b0, 1'b1, Base + 32'd20, ~old);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, Base + 32'd20, 32'h0);
    @(negedge clk);
    rst3 = 1'b0;
    @(posedge clk);
    #1;
    err_m[1] = 1'b0;
    rd_m[1]  = 32'h0;
    checks++;
    if ({bus3.dReadData, bus3.ready, bus3.busy, bus3.err} !== 35'h0) begin
      errors++;
      $display("FAIL abort_outputs: rdata %h ready %b busy %b err %b expected all 0",
               bus3.dReadData, bus3.ready, bus3.busy, bus3.err);
    end
    @(negedge clk);
    rst3 = 1'b1;
    ready_cnt = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus3.ready) ready_cnt++;
    end
    checks++;
    if (ready_cnt !== 0) begin errors++; $display("FAIL abort_no_ready: got %0d pulses expected 0", ready_cnt); end
    do_access(1, 1'b1, 1'b0, Base + 32'd20, 32'h0, lat, rd, e);
    model_apply(1, 1'b1, 1'b0, Base + 32'd20, 32'h0);
    checks++;
    if (rd !== old) begin errors++; $display("FAIL abort_no_write: got %h expected %h", rd, old); end
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] rd; logic e; logic [31:0] old; logic [31:0] exp_rd; logic exp_e;
    old = mem_m[1][0];
`ifdef DMEM_MISALIGN_TRAP_EN
    exp_rd = old;
    exp_e  = 1'b1;
`else
    exp_rd = ~old;
    exp_e  = 1'b0;
`endif
    do_access(1, 1'b0, 1'b1, 32'h1001_0002, ~old, lat, rd, e);
    model_apply(1, 1'b0, 1'b1, 32'h1001_0002, ~old);
    checks++;
    if (e !== exp_e) begin errors++; $display("FAIL misalign_err: got %b expected %b", e, exp_e); end
    do_access(1, 1'b1, 1'b0, 32'h1001_0000, 32'h0, lat, rd, e);
    model_apply(1, 1'b1, 1'b0, 32'h1001_0000, 32'h0);
    checks++;
    if (rd !== exp_rd) begin errors++; $display("FAIL misalign_word0: got %h expected %h", rd, exp_rd); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd; logic e; logic [31:0] a; logic [31:0] d; int op; int kind;
    for (int n = 0; n < 80; n++) begin
      int w;
      w    = n % 2;
      kind = $urandom_range(0, 9);
      op   = $urandom_range(1, 3);
      d    = $urandom;
      a    = Base + 32'(4 * $urandom_range(0, Depth - 1));
      if (kind == 0) a = Base - 32'(4 * $urandom_range(1, 8));
      else if (kind == 1) a = Base + 32'(4 * Depth) + 32'(4 * $urandom_range(0, 8));
      else if (kind == 2) a = a + 32'($urandom_range(1, 3));
      do_access(w, op[0], op[1], a, d, lat, rd, e);
      model_apply(w, op[0], op[1], a, d);
      checks += 3;
      if (lat !== ((w == 0) ? 1 : 4)) begin
        errors++; $display("FAIL rand_latency[%0d] addr %h: got %0d", n, a, lat);
      end
      if (rd !== rd_m[w]) begin
        errors++; $display("FAIL rand_rdata[%0d] addr %h: got %h expected %h", n, a, rd, rd_m[w]);
      end
      if (e !== err_m[w]) begin
        errors++; $display("FAIL rand_err[%0d] addr %h: got %b expected %b", n, a, e, err_m[w]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_basic_w0();
    test_both_high();
    test_out_of_range();
    test_wait_states();
    test_reset_abort();
    test_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
